// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction fetch memory: the mode encoding,
// the response error codes and the default NOP word.
package instr_mem_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10,
    ERR_PARITY   = 2'b11
  } err_e;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

endpackage

// File: rtl/instr_mem_byte_ram.sv
// Byte-wide instruction storage with one aligned 32-bit word write port and a
// combinational big-endian word read. INSTR_MEM_PARITY_EN adds a per-byte even-parity bit.
module instr_mem_byte_ram #(
  parameter  int DEPTH_BYTES = 1024,
  localparam int AW          = $clog2(DEPTH_BYTES)
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-3:0] wr_idx,
  input  logic [31:0]   wr_data,
`ifdef INSTR_MEM_PARITY_EN
  input  logic          wr_par_inv,
  output logic          rd_par_err,
`endif
  input  logic [AW-3:0] rd_idx,
  output logic [31:0]   rd_data
);

  logic [7:0] mem_q [DEPTH_BYTES];

  // Storage is never reset, so the loaded program survives a reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        mem_q[{wr_idx, 2'(b)}] <= wr_data[31-8*b -: 8];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int b = 0; b < 4; b++) begin
      rd_data[31-8*b -: 8] = mem_q[{rd_idx, 2'(b)}];
    end
  end

`ifdef INSTR_MEM_PARITY_EN
  logic par_q [DEPTH_BYTES];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        par_q[{wr_idx, 2'(b)}] <= (^wr_data[31-8*b -: 8]) ^ wr_par_inv;
      end
    end
  end

  always_comb begin
    rd_par_err = 1'b0;
    for (int b = 0; b < 4; b++) begin
      rd_par_err = rd_par_err | ((^mem_q[{rd_idx, 2'(b)}]) != par_q[{rd_idx, 2'(b)}]);
    end
  end
`endif

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: LOAD/RUN mode FSM, fetch error decode, one-deep response
// register with valid/ready and a saturating fetch counter. Optional macro: INSTR_MEM_PARITY_EN.
//
//   state | meaning
//   LOAD  | loader may write words; no fetches accepted
//   RUN   | fetches served; loader ignored until reset
module instr_fetch_mem
  import instr_mem_pkg::*;
#(
  parameter int          DEPTH_BYTES = 1024,
  parameter int          ADDR_W      = 32,
  parameter logic [31:0] NOP_INSTR   = NOP_INSTR_DEF,
  parameter int          CNT_W       = 32
) (
  input  logic              clock,
  input  logic              reset_n,
`ifdef INSTR_MEM_PARITY_EN
  input  logic              inject_parity_err,
`endif
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              load_done,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_instr,
  output logic [1:0]        resp_err,
  output logic              run_mode,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam int AW = $clog2(DEPTH_BYTES);

  mode_e             state_q, state_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_instr_q, resp_instr_d;
  err_e              resp_err_q, resp_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept;
  logic              load_wr;
  logic              fetch_misalign;
  logic              fetch_oob;
  logic [31:0]       rd_data;
  logic              unused_load_lsb;

  assign unused_load_lsb = ^load_addr[1:0];

  assign run_mode    = (state_q == RUN);
  assign fetch_ready = run_mode && (!resp_valid_q || resp_ready);
  assign accept      = fetch_req && fetch_ready;

  // Anything with an address bit at or above AW lies outside the store.
  assign load_wr        = (state_q == LOAD) && load_en && ((load_addr >> AW) == '0);
  assign fetch_misalign = (fetch_addr[1:0] != 2'b00);
  assign fetch_oob      = ((fetch_addr >> AW) != '0);

`ifdef INSTR_MEM_PARITY_EN
  logic rd_par_err;
`endif

  instr_mem_byte_ram #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_ram (
    .clock      (clock),
    .wr_en      (load_wr),
    .wr_idx     (load_addr[AW-1:2]),
    .wr_data    (load_data),
`ifdef INSTR_MEM_PARITY_EN
    .wr_par_inv (inject_parity_err),
    .rd_par_err (rd_par_err),
`endif
    .rd_idx     (fetch_addr[AW-1:2]),
    .rd_data    (rd_data)
  );

  always_comb begin
    state_d = state_q;
    if (state_q == LOAD && load_done) begin
      state_d = RUN;
    end
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_instr_d = resp_instr_q;
    resp_err_d   = resp_err_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      if (fetch_misalign) begin
        resp_instr_d = NOP_INSTR;
        resp_err_d   = ERR_MISALIGN;
      end else if (fetch_oob) begin
        resp_instr_d = NOP_INSTR;
        resp_err_d   = ERR_RANGE;
`ifdef INSTR_MEM_PARITY_EN
      end else if (rd_par_err) begin
        resp_instr_d = NOP_INSTR;
        resp_err_d   = ERR_PARITY;
`endif
      end else begin
        resp_instr_d = rd_data;
        resp_err_d   = ERR_OK;
      end
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  assign cnt_d = (accept && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= LOAD;
      resp_valid_q <= 1'b0;
      resp_instr_q <= NOP_INSTR;
      resp_err_q   <= ERR_OK;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_instr_q <= resp_instr_d;
      resp_err_q   <= resp_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_instr  = resp_instr_q;
  assign resp_err    = resp_err_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem: a reference model predicts handshakes, counter
// and queued responses; INSTR_MEM_PARITY_EN enables the parity-injection case.
module tb_instr_fetch_mem;

  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          load_en, load_done, fetch_req, resp_ready;
  logic [31:0]   load_addr, load_data, fetch_addr;
  logic          fetch_ready, resp_valid, run_mode;
  logic [31:0]   resp_instr;
  logic [1:0]    resp_err;
  logic [CW-1:0] fetch_count;
`ifdef INSTR_MEM_PARITY_EN
  logic          inject_parity_err;
`endif

  instr_fetch_mem #(
    .DEPTH_BYTES(1024),
    .ADDR_W     (32),
    .NOP_INSTR  (32'h0000_0000),
    .CNT_W      (CW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
`ifdef INSTR_MEM_PARITY_EN
    .inject_parity_err(inject_parity_err),
`endif
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_done  (load_done),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_instr (resp_instr),
    .resp_err   (resp_err),
    .run_mode   (run_mode),
    .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  err;
  } resp_t;

  logic [7:0] m_mem [1024];
  bit         m_bad [256];
  bit         m_run, m_valid;
  int         m_cnt;
  resp_t      exp_q [$];

  // Checks outputs 1 time unit after a falling edge, then advances the model across
  // the rising edge and returns on the next falling edge.
  task automatic tick();
    bit          acc;
    bit          inj;
    resp_t       r;
    logic [9:0]  base;
    #1;
    chk("fetch_ready", fetch_ready, m_run && (!m_valid || resp_ready));
    chk("resp_valid", resp_valid, m_valid);
    chk("run_mode", run_mode, m_run);
    chk("fetch_count", fetch_count, m_cnt);
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL resp_queue: got valid response want none pending");
      end else begin
        chk("resp_instr", resp_instr, exp_q[0].instr);
        chk("resp_err", resp_err, exp_q[0].err);
      end
    end
`ifdef INSTR_MEM_PARITY_EN
    inj = inject_parity_err;
`else
    inj = 1'b0;
`endif
    acc = m_run && fetch_req && (!m_valid || resp_ready);
    if (m_valid && resp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    if (acc) begin
      r.instr = 32'h0;
      if (fetch_addr[1:0] != 2'b00)        r.err = 2'b01;
      else if (fetch_addr >= 32'd1024)     r.err = 2'b10;
      else if (m_bad[fetch_addr[9:2]])     r.err = 2'b11;
      else begin
        base    = fetch_addr[9:0];
        r.err   = 2'b00;
        r.instr = {m_mem[base], m_mem[base+10'd1], m_mem[base+10'd2], m_mem[base+10'd3]};
      end
      exp_q.push_back(r);
      m_valid = 1'b1;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end else if (resp_ready) begin
      m_valid = 1'b0;
    end
    if (!m_run) begin
      if (load_en && load_addr < 32'd1024) begin
        base = {load_addr[9:2], 2'b00};
        m_mem[base]       = load_data[31:24];
        m_mem[base+10'd1] = load_data[23:16];
        m_mem[base+10'd2] = load_data[15:8];
        m_mem[base+10'd3] = load_data[7:0];
        m_bad[load_addr[9:2]] = inj;
      end
      if (load_done) m_run = 1'b1;
    end
    @(negedge clock);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d, input logic done);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    load_done = done;
    tick();
    load_en   = 1'b0;
    load_done = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    tick();
    fetch_req  = 1'b0;
  endtask

  // Asserts reset mid-cycle and checks that the outputs clear without waiting for an edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_run_mode", run_mode, 0);
    chk("rst_fetch_ready", fetch_ready, 0);
    chk("rst_resp_instr", resp_instr, 32'h0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_fetch_count", fetch_count, 0);
    m_run   = 1'b0;
    m_valid = 1'b0;
    m_cnt   = 0;
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    load_en    = 1'b0;
    load_done  = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    resp_ready = 1'b1;
`ifdef INSTR_MEM_PARITY_EN
    inject_parity_err = 1'b0;
`endif
    @(negedge clock);
    do_reset();

    do_load(32'h0000_0000, 32'h8020_000A, 1'b0);
    do_load(32'h0000_0010, 32'h1122_3344, 1'b0);
    do_load(32'h0000_0014, 32'h5566_7788, 1'b0);
    do_load(32'h0000_0018, 32'h99AA_BBCC, 1'b0);
    do_load(32'h0000_0400, 32'hDEAD_BEEF, 1'b0);
    do_load(32'h0000_0023, 32'hCAFE_F00D, 1'b0);
`ifdef INSTR_MEM_PARITY_EN
    inject_parity_err = 1'b1;
    do_load(32'h0000_0004, 32'h1234_5678, 1'b0);
    inject_parity_err = 1'b0;
`endif
    do_load(32'h0000_001C, 32'h0BAD_F00D, 1'b1);
    tick();

    do_fetch(32'h0000_0000);
    tick();

    fetch_req = 1'b1;
    foreach (exp_q[i]) ;
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 32'h10 + 32'(4 * i);
      tick();
    end
    fetch_req = 1'b0;
    tick();
    tick();

    do_fetch(32'h0000_0002);
    do_fetch(32'h0000_0400);
    do_fetch(32'h0000_0401);
    do_fetch(32'h0000_0020);
    do_fetch(32'h0000_001C);
    do_fetch(32'hFFFF_FFFC);
    do_fetch(32'h0000_03FC);
`ifdef INSTR_MEM_PARITY_EN
    do_fetch(32'h0000_0004);
    do_fetch(32'h0000_0000);
`endif
    tick();

    resp_ready = 1'b0;
    do_fetch(32'h0000_0010);
    fetch_req  = 1'b1;
    fetch_addr = 32'h0000_0014;
    for (int i = 0; i < 3; i++) tick();
    resp_ready = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    tick();

    do_load(32'h0000_0000, 32'hDEAD_BEEF, 1'b1);
    do_fetch(32'h0000_0000);
    tick();

    fetch_req  = 1'b1;
    fetch_addr = 32'h0000_0018;
    for (int i = 0; i < 16; i++) tick();
    fetch_req = 1'b0;
    tick();

    resp_ready = 1'b0;
    do_fetch(32'h0000_0014);
    tick();
    do_reset();
    tick();
    load_done = 1'b1;
    tick();
    load_done  = 1'b0;
    resp_ready = 1'b1;
    do_fetch(32'h0000_0000);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
